shift_capture: RTL
==================

// Module: shift_capture
// PURPOSE
//  Receive end of the processor's serial shift path. During Execute the register
//  units emit one A bit and one B bit per Clk while Shift_En is high, LSB first.
//  This block rebuilds those bits into WIDTH-bit A/B words and buffers them in a
//  DEPTH-entry FIFO. Downstream logic (display, logger) drains the FIFO over a
//  valid/ready port.
// PARAMETERS
//  WIDTH  8  bits per captured word; must equal the register width
//  DEPTH  4  FIFO entries, power of two, >= 2
// PORTS
//  Clk        in   1              system clock; all state updates on rising edge
//  Reset      in   1              asynchronous, active-low reset
//  Shift_En   in   1              serial bit strobe from the control unit
//  A_In       in   1              serial A bit (register A_out)
//  B_In       in   1              serial B bit (register B_out)
//  Out_Ready  in   1              consumer accepts the head entry
//  Out_Valid  out  1              FIFO non-empty
//  A_Word     out  WIDTH          head entry, A word
//  B_Word     out  WIDTH          head entry, B word
//  Count      out  clog2(DEPTH+1) FIFO occupancy, 0..DEPTH
//  Busy       out  1              word capture in progress (state != IDLE)
//  Overflow   out  1              sticky: a completed word was dropped because the FIFO was full
//  Proto_Err  out  1              sticky: Shift_En was high during COMMIT
// BEHAVIOUR
//  - Reset low, asynchronous:
//    - All outputs 0; FIFO emptied; bit counter 0; state IDLE.
//    - A_Word and B_Word read 0 while the FIFO is empty.
//  - Shift registers: on each sampled bit, sa <= {A_In, sa[WIDTH-1:1]} (sb likewise).
//    After WIDTH bits, sa equals the original A register value.
//  - FSM:
//    - IDLE: Shift_En=1 samples bit 0, bit_cnt <= 1, go to SHIFT.
//    - SHIFT: each Shift_En=1 samples a bit and increments bit_cnt.
//      - Shift_En=0 holds state; a partial word is retained.
//      - The edge that samples bit WIDTH-1 goes to COMMIT.
//    - COMMIT: exactly one cycle.
//      - Pushes {sa,sb} if Count<DEPTH, else drops the word and sets Overflow.
//      - bit_cnt <= 0; go to IDLE.
//      - A Shift_En=1 in COMMIT is ignored and sets Proto_Err.
//  - Latency: Out_Valid rises on the second edge after the last bit is sampled
//    (the COMMIT edge), when the FIFO was empty.
//  - Pop: Out_Valid && Out_Ready removes the head at the edge.
//    - A_Word/B_Word show the next entry combinationally from the read pointer.
//  - Push and pop in the same cycle:
//    - Count is unchanged.
//    - When full, the pop frees a slot and the push is accepted; Overflow is not set.
//  - Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is a separate counter
//    so full and empty are unambiguous.
//  - Out_Ready while empty: no effect.
//  - Overflow and Proto_Err clear only on Reset.
// CONFIGURATION
//  SHIFT_CAPTURE_ABORT_EN
//    - Defined: in SHIFT, one cycle of Shift_En=0 discards the partial word.
//      - bit_cnt <= 0, go to IDLE, nothing is pushed.
//      - The control unit shifts WIDTH bits back-to-back, so any gap is treated as an aborted Execute.
//    - Undefined: a partial word is held indefinitely and resumes on the next Shift_En.
// TESTING
//  1. A=8'hA5, B=8'h3C shifted LSB first, 8 consecutive Shift_En cycles
//     -> Out_Valid high 2 edges after the last bit; A_Word=8'hA5, B_Word=8'h3C; Count=1.
//  2. Five words (8'h01..8'h05 on A), Out_Ready=0, DEPTH=4
//     -> Count=4; Overflow=1; pops return 8'h01..8'h04 in order.
//  3. FIFO full, Out_Ready=1 held through the COMMIT of word 5
//     -> Overflow stays 0; Count stays 4; word 5 is the last entry popped.
//  4. Shift 3 bits, Shift_En low 5 cycles, shift 5 bits of 8'hF0/8'h0F:
//     - macro undefined -> word 8'hF0/8'h0F pushed.
//     - macro defined -> first 3 bits dropped; Busy=0 after the gap; no push until 8 further bits.
//  5. Shift_En held 9 cycles -> one word pushed; Proto_Err=1.
//  6. Reset asserted mid-word (bit 4) with Count=2
//     -> all outputs 0 immediately; a fresh 8-bit word is captured correctly after release.

Source files
------------

// File: rtl/shift_capture_if.sv
// Interface bundling the serial capture inputs and the FIFO drain port of
// shift_capture. The DUT side uses the slave modport; the producer/consumer
// side (control unit, display, logger or a bench) uses master.
interface shift_capture_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             Shift_En;
  logic             A_In;
  logic             B_In;
  logic             Out_Ready;
  logic             Out_Valid;
  logic [WIDTH-1:0] A_Word;
  logic [WIDTH-1:0] B_Word;
  logic [OCC_W-1:0] Count;
  logic             Busy;
  logic             Overflow;
  logic             Proto_Err;

  modport slave (
    input  Shift_En, A_In, B_In, Out_Ready,
    output Out_Valid, A_Word, B_Word, Count, Busy, Overflow, Proto_Err
  );

  modport master (
    output Shift_En, A_In, B_In, Out_Ready,
    input  Out_Valid, A_Word, B_Word, Count, Busy, Overflow, Proto_Err
  );
endinterface

// File: rtl/shift_capture.sv
// shift_capture: rebuilds the serial A/B shift stream (LSB first) into
// WIDTH-bit words and buffers them in a DEPTH-entry FIFO drained over a
// valid/ready port.
// Build option: define SHIFT_CAPTURE_ABORT_EN to discard a partial word as
// soon as Shift_En drops during SHIFT; otherwise a partial word is held and
// resumes on the next Shift_En.
//
// state  | meaning
// IDLE   | no word in progress, bit_cnt = 0
// SHIFT  | word partially captured, bit_cnt = bits sampled so far
// COMMIT | full word in sa/sb, pushed (or dropped when full) this cycle
module shift_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic           Clk,
  input logic           Reset,
  shift_capture_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   sa, sb;
  logic               sample, cnt_inc, cnt_clr, commit, proto_set;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] head;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [OCC_W-1:0]   count;
  logic               overflow, proto_err;
  logic               empty, full, pop, push, ovf_set;

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    commit    = 1'b0;
    proto_set = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Shift_En) begin
          sample    = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.Shift_En) begin
          sample = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = COMMIT;
          else                     cnt_inc   = 1'b1;
        end else begin
`ifdef SHIFT_CAPTURE_ABORT_EN
          // Execute never pauses mid-word, so a gap means it was aborted.
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        cnt_clr   = 1'b1;
        proto_set = bus.Shift_En;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter and the two deserialising shift registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bit_cnt <= '0;
      sa      <= '0;
      sb      <= '0;
    end else begin
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);
      if (sample) begin
        sa <= {bus.A_In, sa[WIDTH-1:1]};
        sb <= {bus.B_In, sb[WIDTH-1:1]};
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = !empty && bus.Out_Ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = commit && (!full || pop);
  assign ovf_set = commit && full && !pop;

  // FIFO storage; contents are only visible through the empty-gated head.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {sa, sb};
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + OCC_W'(1);
      else if (pop && !push) count <= count - OCC_W'(1);
      if (ovf_set)   overflow  <= 1'b1;
      if (proto_set) proto_err <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.Out_Valid = !empty;
  assign bus.A_Word    = empty ? '0 : head[2*WIDTH-1:WIDTH];
  assign bus.B_Word    = empty ? '0 : head[WIDTH-1:0];
  assign bus.Count     = count;
  assign bus.Busy      = (state != IDLE);
  assign bus.Overflow  = overflow;
  assign bus.Proto_Err = proto_err;
endmodule
